// File: rtl/seq_ctrl_pkg.sv
// Shared types and helpers for the go/done stage sequencer.
package seq_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFinish
  } seq_state_e;

  localparam int unsigned MinIdxW   = 1;
  localparam int unsigned MaxStages = 32;

  // Lowest set bit of mask above (or at, when inclusive) from; result is {none_left, idx}.
  function automatic logic [5:0] next_set_idx(input logic [31:0] mask,
                                               input logic [4:0]  from,
                                               input logic        inclusive);
    logic [5:0] res;
    res = 6'b10_0000;
    for (int i = 31; i >= 0; i--) begin
      if (mask[i] && ((i > int'(from)) || (inclusive && (i == int'(from))))) begin
        res = {1'b0, 5'(i)};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/seq_next_stage.sv
// Combinational priority encoder: next enabled stage index at/after a start point.
module seq_next_stage
  import seq_ctrl_pkg::*;
#(
  parameter int unsigned NumStages = 4,
  parameter int unsigned IdxW      = 2
) (
  input  logic [NumStages-1:0] mask_i,
  input  logic [IdxW-1:0]      from_i,
  input  logic                 inclusive_i,
  output logic [IdxW-1:0]      idx_o,
  output logic                 none_left_o
);

  logic [5:0] res;

  always_comb begin
    res         = next_set_idx(32'(mask_i), 5'(from_i), inclusive_i);
    idx_o       = IdxW'(res[4:0]);
    none_left_o = res[5];
  end

endmodule

// File: rtl/seq_go_done_ctrl.sv
// Go/done initiator: runs enabled child stages in index order, then pulses done to the parent.
// Optional per-stage watchdog with sticky error when SEQ_CTRL_TIMEOUT_EN is defined.
module seq_go_done_ctrl
  import seq_ctrl_pkg::*;
#(
  parameter int unsigned NumStages     = 4,
  parameter int unsigned IdxW          = (NumStages > 1) ? $clog2(NumStages) : MinIdxW,
  parameter int unsigned TimeoutCycles = 255
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 go_i,
  input  logic [NumStages-1:0] stage_en_i,
  input  logic [NumStages-1:0] stage_done_i,
  output logic [NumStages-1:0] stage_go_o,
  output logic                 done_o,
  output logic                 busy_o,
  output logic [IdxW-1:0]      cur_stage_o,
  output logic                 error_o
);

  seq_state_e           state_q, state_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic [NumStages-1:0] en_q, en_d;

  logic [NumStages-1:0] ns_mask;
  logic [IdxW-1:0]      ns_from;
  logic                 ns_inclusive;
  logic [IdxW-1:0]      ns_idx;
  logic                 ns_none;
  logic                 done_cur;
  logic                 timeout;

  // In IDLE search the live enable mask from stage 0; in RUN search the latched mask above idx.
  assign ns_inclusive = (state_q == StIdle);
  assign ns_mask      = ns_inclusive ? stage_en_i : en_q;
  assign ns_from      = ns_inclusive ? '0 : idx_q;
  assign done_cur     = stage_done_i[idx_q];

  seq_next_stage #(
    .NumStages (NumStages),
    .IdxW      (IdxW)
  ) u_next_stage (
    .mask_i      (ns_mask),
    .from_i      (ns_from),
    .inclusive_i (ns_inclusive),
    .idx_o       (ns_idx),
    .none_left_o (ns_none)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    en_d       = en_q;
    stage_go_o = '0;
    done_o     = 1'b0;
    case (state_q)
      StIdle: begin
        if (go_i) begin
          en_d = stage_en_i;
          if (!ns_none) begin
            idx_d   = ns_idx;
            state_d = StRun;
          end else begin
            state_d = StFinish;
          end
        end
      end
      StRun: begin
        // Gate go with the child's done so it is never re-triggered on its completion cycle.
        stage_go_o[idx_q] = !done_cur;
        if (done_cur) begin
          if (ns_none) begin
            state_d = StFinish;
          end else begin
            idx_d = ns_idx;
          end
        end else if (timeout) begin
          state_d = StFinish;
        end
      end
      StFinish: begin
        done_o  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      idx_q   <= '0;
      en_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      en_q    <= en_d;
    end
  end

  assign busy_o      = (state_q != StIdle);
  assign cur_stage_o = idx_q;

`ifdef SEQ_CTRL_TIMEOUT_EN
  localparam int unsigned TimerW = $clog2(TimeoutCycles + 1);

  logic [TimerW-1:0] timer_q, timer_d;
  logic              error_q, error_d;

  // Counts waiting cycles of the current stage; any other cycle restarts it.
  always_comb begin
    timer_d = '0;
    error_d = error_q;
    timeout = 1'b0;
    if ((state_q == StRun) && !done_cur) begin
      if (timer_q == TimerW'(TimeoutCycles - 1)) begin
        timeout = 1'b1;
        error_d = 1'b1;
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      timer_q <= '0;
      error_q <= 1'b0;
    end else begin
      timer_q <= timer_d;
      error_q <= error_d;
    end
  end

  assign error_o = error_q;
`else
  assign timeout = 1'b0;
  assign error_o = 1'b0;
`endif

endmodule

// File: doc/seq_go_done_ctrl.md
Name: seq_go_done_ctrl

Overview:
Initiator side of the go/done component handshake used by our datapath primitives (registers, multi-cycle units). Accepts one go/done handshake from its parent. Then it drives go into up to NUM_STAGES child components in strict index order, waiting for each child's done before moving on. After the last enabled stage it returns a single-cycle done to the parent. It is the control glue placed above chains of register/adder stages in user designs mapped to the fabric.

Parameters:
NUM_STAGES, 4, number of child components sequenced (1..32)
IDX_W, $clog2(NUM_STAGES) (min 1), width of cur_stage
TIMEOUT_CYCLES, 255, watchdog limit per stage (used only with SEQ_CTRL_TIMEOUT_EN)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
go  input  1  parent start; level, held by parent until done seen
stage_en  input  NUM_STAGES  per-stage enable mask, sampled when run starts
stage_done  input  NUM_STAGES  done from each child
stage_go  output  NUM_STAGES  go to each child (one-hot or zero)
done  output  1  one-cycle completion pulse to parent
busy  output  1  high in RUN and FINISH
cur_stage  output  IDX_W  index of active stage (valid while RUN)
error  output  1  sticky watchdog flag (0 when feature compiled out)

Behaviour:
- Reset (reset==0, async): state=IDLE, idx=0, en_q=0, done=0, busy=0, stage_go=0, cur_stage=0, error=0, timer=0.
- States: IDLE, RUN, FINISH; state encoding is an enum from the package.
- IDLE: done=0, stage_go=0. If go==1 at a clock edge, latch en_q<=stage_en.
  - If stage_en has any bit set: idx<=lowest set index, state<=RUN.
  - Else: state<=FINISH (zero-stage run, done in cycle after go).
- RUN: stage_go[idx] = !stage_done[idx] (combinational gate on a registered decode). All other bits are 0. This ensures a child is never re-triggered in the cycle its done is high.
  - On an edge with stage_done[idx]==1: idx<=next set bit of en_q above idx. If none exists, state<=FINISH.
  - stage_done bits other than idx are ignored.
  - stage_done[idx] already high on the first RUN cycle counts as completion (0-go-cycle stage).
- FINISH: done=1 for exactly one cycle, then state<=IDLE. The parent must drop go combinationally on done. If go is still high in the next IDLE cycle, a new run starts (defined behaviour, not an error).
- go dropping mid-run is ignored; the run completes.
- Latency with single-cycle children (done one cycle after go):
  - go cycle 0.
  - stage k go in cycle 1+2k.
  - done at cycle 2E+1, where E = number of enabled stages.
- cur_stage = idx; busy = (state!=IDLE).
- Async reset mid-run: all outputs are forced to reset values immediately, including stage_go=0. The child's own state is its own responsibility.

Optional Feature:
SEQ_CTRL_TIMEOUT_EN
- Defined:
  - A per-stage counter clears on entering each stage and increments every RUN cycle without stage_done[idx].
  - When it reaches TIMEOUT_CYCLES: error<=1 (sticky until reset), stage_go<=0, state<=FINISH, so the parent still receives done.
- Undefined: no counter, error tied to 0, RUN waits indefinitely.

Decomposition:
Package seq_ctrl_pkg holds:
- seq_state_e (IDLE, RUN, FINISH)
- the constant for the minimum IDX_W
- a function next_set_idx(mask, from, inclusive)

One sub-module is natural: seq_next_stage, a combinational priority encoder returning the next enabled index plus a none_left flag. It is used both at start (inclusive from 0) and on advance (exclusive from idx).

Test Plan:
1. NUM_STAGES=4, stage_en=4'b1111, children are std-register-style (done 1 cycle after go), go at cycle 0 -> stage_go = 0001@1, 0010@3, 0100@5, 1000@7; done=1 only at cycle 9; each child written exactly once.
2. stage_en=4'b1010 -> stage_go[1]@1, stage_go[3]@3, done@5; stages 0 and 2 never see go.
3. stage_en=4'b0000, go=1 -> done@1, stage_go stays 0, busy high only in cycle 1.
4. Stage 2 child holds done low 10 cycles -> stage_go[2] held 1 for those cycles, cur_stage=2; stray stage_done[0] pulse during this wait has no effect.
5. Assert reset low at cycle 4 of case 1 -> stage_go, done, busy go to 0 immediately; after release, go restarts from stage 0 with full timing of case 1.
6. SEQ_CTRL_TIMEOUT_EN, TIMEOUT_CYCLES=8, stage 1 never completes -> error=1 after 8 waiting cycles, done pulse the next cycle, stages 2–3 skipped, error stays 1 through a subsequent clean run.
